// File: rtl/lockin_csr_bank.sv
// ============================================================================
// Module   : lockin_csr_bank
// Purpose  : Avalon-MM CSR bank for the multi-channel lock-in: double-buffered
//            phase registers, X/Y snapshots, global fields, timed reset request.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lockin_csr_bank #(
  parameter int NUM_CH    = 8,
  parameter int PHASE_W   = 20,
  parameter int LIA_W     = 16,
  parameter int RST_PULSE = 16
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  input  logic [7:0]                avs_address,
  input  logic                      avs_write,
  input  logic                      avs_read,
  input  logic [31:0]               avs_writedata,
  output logic [31:0]               avs_readdata,
  output logic                      avs_readdatavalid,
  input  logic                      sync_in,
  input  logic [NUM_CH*LIA_W-1:0]   lia_x_export,
  input  logic [NUM_CH*LIA_W-1:0]   lia_y_export,
  output logic [NUM_CH*PHASE_W-1:0] phase_incr_export,
  output logic [NUM_CH*PHASE_W-1:0] phase_offs_export,
  output logic [7:0]                control_bits_export,
  output logic [5:0]                gain_ctrl_export,
  output logic [7:0]                dac_gain_export,
  output logic [7:0]                dac_div_export,
  output logic                      resetrequest_reset
);

  localparam int          c_rst_w     = $clog2(RST_PULSE + 1);
  localparam logic [7:0]  c_addr_ctrl = 8'h00;
  localparam logic [7:0]  c_addr_gain = 8'h01;
  localparam logic [7:0]  c_addr_dacg = 8'h02;
  localparam logic [7:0]  c_addr_dacd = 8'h03;
  localparam logic [7:0]  c_addr_cmd  = 8'h04;
  localparam logic [7:0]  c_addr_mode = 8'h05;
  localparam logic [7:0]  c_addr_info = 8'h06;
  localparam logic [7:0]  c_addr_rst  = 8'h07;
  localparam logic [31:0] c_info      = {8'd0, 8'(LIA_W), 8'(PHASE_W), 8'(NUM_CH)};

  logic [7:0]          r_control_bits, r_dac_gain, r_dac_div, r_snap_count;
  logic [5:0]          r_gain_ctrl;
  logic                r_commit_on_sync, r_commit_pending;
  logic [c_rst_w-1:0]  r_rst_cnt;
  logic [PHASE_W-1:0]  r_shadow_incr [NUM_CH];
  logic [PHASE_W-1:0]  r_shadow_offs [NUM_CH];
  logic [PHASE_W-1:0]  r_active_incr [NUM_CH];
  logic [PHASE_W-1:0]  r_active_offs [NUM_CH];
  logic [LIA_W-1:0]    r_snap_x [NUM_CH];
  logic [LIA_W-1:0]    r_snap_y [NUM_CH];

  logic        w_cmd_wr, w_commit_req, w_snap_req, w_transfer, w_key;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_cmd_wr     = avs_write && (avs_address == c_addr_cmd);
  assign w_commit_req = w_cmd_wr && avs_writedata[0];
  assign w_snap_req   = w_cmd_wr && avs_writedata[1];
  // A pending commit fires on sync, or immediately once sync mode is dropped.
  // A fresh commit request never sees the sync of its own cycle.
  assign w_transfer   = (w_commit_req && !r_commit_on_sync) ||
                        (r_commit_pending && (sync_in || !r_commit_on_sync));
  assign w_key        = avs_write && (avs_address == c_addr_rst) &&
                        (avs_writedata[7:0] == 8'hA5);
  assign w_unused     = &{1'b0, avs_writedata};

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_control_bits    <= '0;
      r_gain_ctrl       <= '0;
      r_dac_gain        <= '0;
      r_dac_div         <= 8'd1;
      r_commit_on_sync  <= 1'b0;
      r_commit_pending  <= 1'b0;
      r_snap_count      <= '0;
      r_rst_cnt         <= '0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      if (avs_write) begin
        case (avs_address)
          c_addr_ctrl: r_control_bits   <= avs_writedata[7:0];
          c_addr_gain: r_gain_ctrl      <= avs_writedata[5:0];
          c_addr_dacg: r_dac_gain       <= avs_writedata[7:0];
          c_addr_dacd: r_dac_div        <= avs_writedata[7:0];
          c_addr_mode: r_commit_on_sync <= avs_writedata[0];
          default: ;
        endcase
      end
      if (w_commit_req && r_commit_on_sync) r_commit_pending <= 1'b1;
      else if (w_transfer)                  r_commit_pending <= 1'b0;
      if (w_snap_req) r_snap_count <= r_snap_count + 8'd1;
      if (r_rst_cnt != '0) r_rst_cnt <= r_rst_cnt - 1'b1;
      else if (w_key)      r_rst_cnt <= c_rst_w'(RST_PULSE);
      avs_readdatavalid <= avs_read;
      avs_readdata      <= avs_read ? w_rdata : '0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_shadow_incr[k] <= '0;
        r_shadow_offs[k] <= '0;
        r_active_incr[k] <= '0;
        r_active_offs[k] <= '0;
        r_snap_x[k]      <= '0;
        r_snap_y[k]      <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (avs_write && avs_address == 8'(16 + 2*k))
          r_shadow_incr[k] <= avs_writedata[PHASE_W-1:0];
        if (avs_write && avs_address == 8'(17 + 2*k))
          r_shadow_offs[k] <= avs_writedata[PHASE_W-1:0];
        // Nonblocking semantics make a coincident shadow write land after the copy.
        if (w_transfer) begin
          r_active_incr[k] <= r_shadow_incr[k];
          r_active_offs[k] <= r_shadow_offs[k];
        end
        if (w_snap_req) begin
          r_snap_x[k] <= lia_x_export[k*LIA_W +: LIA_W];
          r_snap_y[k] <= lia_y_export[k*LIA_W +: LIA_W];
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (avs_address)
      c_addr_ctrl: w_rdata = {24'd0, r_control_bits};
      c_addr_gain: w_rdata = {26'd0, r_gain_ctrl};
      c_addr_dacg: w_rdata = {24'd0, r_dac_gain};
      c_addr_dacd: w_rdata = {24'd0, r_dac_div};
      c_addr_cmd:  w_rdata = {16'd0, r_snap_count, 7'd0, r_commit_pending};
      c_addr_mode: w_rdata = {31'd0, r_commit_on_sync};
      c_addr_info: w_rdata = c_info;
      default: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (avs_address == 8'(16 + 2*k)) w_rdata = 32'(r_shadow_incr[k]);
          if (avs_address == 8'(17 + 2*k)) w_rdata = 32'(r_shadow_offs[k]);
          if (avs_address == 8'(64 + 2*k)) w_rdata = 32'($signed(r_snap_x[k]));
          if (avs_address == 8'(65 + 2*k)) w_rdata = 32'($signed(r_snap_y[k]));
        end
      end
    endcase
  end

  always_comb begin
    phase_incr_export = '0;
    phase_offs_export = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      phase_incr_export[k*PHASE_W +: PHASE_W] = r_active_incr[k];
      phase_offs_export[k*PHASE_W +: PHASE_W] = r_active_offs[k];
    end
  end

  assign control_bits_export = r_control_bits;
  assign gain_ctrl_export    = r_gain_ctrl;
  assign dac_gain_export     = r_dac_gain;
  assign dac_div_export      = r_dac_div;
  assign resetrequest_reset  = (r_rst_cnt != '0);

endmodule

`default_nettype wire
